shared_reg_arbiter: RTL and testbench

Round-robin write arbiter for one shared WIDTH-bit D-register. N_REQ requesters compete for write ownership, and exactly one owns the register at a time. Each write by the owner is captured on the next rising edge. An ownership tenure is capped at MAX_HOLD writes whenever another requester is waiting. The block sits in front of the flip-flop storage and is the only agent allowed to drive its D input and load enable.

---
 rtl/reg_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 23 ++
 rtl/shared_reg_arbiter.sv | 94 +++++++++
 tb/tb_shared_reg_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin shared-register write arbiter.
// Holds the FSM state encoding and the one-hot grant helper.
package reg_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;

  // Widest requester count the helper supports; the caller truncates.
  localparam int MAX_REQ = 16;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] index, input int n);
    logic [MAX_REQ-1:0] mask;
    mask   = MAX_REQ'((32'd1 << n) - 32'd1);
    onehot = (MAX_REQ'(1) << index) & mask;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker.
// Search starts just after the last owner and wraps around.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             any
);

  assign any = |req;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) winner = IW'((int'(last) + k) % N_REQ);
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Owner tenure is capped at MAX_HOLD writes only while someone else waits.
module shared_reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 3,
  parameter int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       grant,
  output logic [IW-1:0]          owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic             state, state_nxt;
  logic [IW-1:0]    last, winner;
  logic             any;
  logic [HW-1:0]    hold_cnt;
  logic [N_REQ-1:0] win_oh;
  logic [WIDTH-1:0] wr_sel;
  logic             own_req, at_cap, others;
  logic             do_grant, do_write, do_end;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  assign win_oh  = N_REQ'(onehot(4'(winner), N_REQ));
  assign wr_sel  = wr_data[owner*WIDTH +: WIDTH];
  assign own_req = req[owner];
  assign at_cap  = (hold_cnt == HW'(MAX_HOLD - 1));
  assign others  = |(req & ~grant);
  assign busy    = (state == ST_OWNED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any) state_nxt = ST_OWNED;
      ST_OWNED: if (!own_req || (at_cap && others)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A preempting write still lands; the tenure ends on the same edge.
  always_comb begin
    do_grant = (state == ST_IDLE) && any;
    do_write = (state == ST_OWNED) && own_req;
    do_end   = (state == ST_OWNED) && (!own_req || (at_cap && others));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= '0;
      owner    <= '0;
      last     <= IW'(N_REQ - 1);
      hold_cnt <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
    end else begin
      if (do_grant) begin
        grant    <= win_oh;
        owner    <= winner;
        hold_cnt <= '0;
      end
      if (do_write) begin
        q       <= wr_sel;
        q_valid <= 1'b1;
        if (!do_end && !at_cap) hold_cnt <= hold_cnt + HW'(1);
      end
      if (do_end) begin
        grant <= '0;
        last  <= owner;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scenario bench for shared_reg_arbiter with a tenure-level reference model.
// The model counts writes per tenure and picks winners by a modular scan.
module tb_shared_reg_arbiter;
  localparam int N = 4, W = 8, MH = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wr_data = '0;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         busy;
  logic [W-1:0] q;
  logic         q_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns, how many writes this tenure, register contents.
  int       m_owner, m_last, m_cnt;
  bit       m_busy, m_qv;
  logic [W-1:0] m_q;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .wr_data(wr_data),
    .grant(grant), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = 0; m_last = N - 1; m_cnt = 0; m_busy = 0; m_qv = 0; m_q = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] r;
    logic [N-1:0] mine;
    r = req;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && r[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N; m_busy = 1; m_cnt = 0;
        end
      end
    end else if (r[m_owner]) begin
      m_q = wr_data[m_owner*W +: W];
      m_qv = 1;
      m_cnt++;
      mine = '0;
      mine[m_owner] = 1'b1;
      if (m_cnt >= MH && (r & ~mine) != '0) begin
        m_busy = 0; m_last = m_owner;
      end
    end else begin
      m_busy = 0; m_last = m_owner;
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    req = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, owner, busy, q_valid, q} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {grant, owner, busy, q_valid, q}, 16'h0);
    end
  endtask

  task automatic test_lone();
    do_reset();
    req = 4'b0001;
    wr_data[0 +: W] = 8'hA5;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant !== m_grant()) begin
      errors++; $display("FAIL lone_grant: got %b expected %b", grant, 4'b0001);
    end
    checks++;
    if (q_valid !== 1'b0) begin
      errors++; $display("FAIL lone_no_early_write: got %b expected %b", q_valid, 1'b0);
    end
    tick();
    checks++;
    if (q !== 8'hA5 || q_valid !== 1'b1) begin
      errors++; $display("FAIL lone_first_write: got %h/%b expected a5/1", q, q_valid);
    end
    for (int i = 0; i < 10; i++) begin
      wr_data[0 +: W] = W'($urandom);
      wr_data[W +: 3*W] = 24'($urandom);
      tick();
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1 || q !== m_q) begin
        errors++; $display("FAIL lone_hold[%0d]: got %b/%h expected 0001/%h", i, grant, q, m_q);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [N-1:0] prev;
    int run, zrun;
    do_reset();
    for (int i = 0; i < N; i++) wr_data[i*W +: W] = W'(8'h10 * (i + 1) + i);
    req = 4'b1111;
    prev = '0; run = 0; zrun = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (grant !== m_grant() || q !== m_q) begin
        errors++; $display("FAIL rr_cycle[%0d]: got %b/%h expected %b/%h", c, grant, q, m_grant(), m_q);
      end
      if (grant != '0) begin
        if (prev == '0) begin
          for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
          if (order.size() > 1) begin
            checks++;
            if (zrun != 1) begin errors++; $display("FAIL rr_gap: got %0d expected 1", zrun); end
          end
          run = 0;
        end
        run++;
      end else begin
        if (prev != '0) begin
          checks++;
          if (run != MH) begin errors++; $display("FAIL rr_tenure_len: got %0d expected %0d", run, MH); end
          zrun = 0;
        end
        zrun++;
      end
      prev = grant;
    end
    checks++;
    if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3 || order[4] != 0) begin
      errors++; $display("FAIL rr_order: got %p expected 0,1,2,3,0", order);
    end
    req = '0;
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b0100;
    wr_data[2*W +: W] = 8'hC2;
    wr_data[0 +: W] = 8'h0D;
    tick();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rel_grant2: got %b expected 0100", grant); end
    req = 4'b0101;
    tick();
    checks++;
    if (q !== 8'hC2 || grant !== 4'b0100) begin
      errors++; $display("FAIL rel_write2: got %h/%b expected c2/0100", q, grant);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0000 || q !== 8'hC2 || busy !== 1'b0) begin
      errors++; $display("FAIL rel_idle: got %b/%h expected 0000/c2", grant, q);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++; $display("FAIL rel_next: got %b expected 0001", grant);
    end
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    wr_data[3*W +: W] = 8'h33;
    tick();
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL wrap_release: got %b expected 0000", grant); end
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant !== m_grant()) begin
      errors++; $display("FAIL wrap_grant: got %b expected 0001", grant);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    wr_data[2*W +: W] = 8'h3C;
    tick();
    tick();
    checks++;
    if (q !== 8'h3C || busy !== 1'b1) begin
      errors++; $display("FAIL areset_setup: got %h/%b expected 3c/1", q, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || q !== '0 || q_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_clear: got %b/%h/%b/%b expected 0000/00/0/0", grant, q, q_valid, busy);
    end
    model_reset();
    req = 4'b0010;
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0010 || grant !== m_grant()) begin
      errors++; $display("FAIL areset_regrant: got %b expected 0010", grant);
    end
    req = '0;
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0010;
    wr_data[W +: W] = 8'h11;
    tick();
    tick();
    wr_data[W +: W] = 8'h22;
    tick();
    wr_data[W +: W] = 8'h5E;
    wr_data[3*W +: W] = 8'hEE;
    req = 4'b1010;
    tick();
    checks++;
    if (grant !== 4'b0000 || q !== 8'h5E || grant !== m_grant()) begin
      errors++; $display("FAIL preempt_third_write: got %b/%h expected 0000/5e", grant, q);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      errors++; $display("FAIL preempt_next: got %b expected 1000", grant);
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      wr_data = {$urandom};
      tick();
      checks++;
      if ({grant, owner, busy, q_valid, q} !== {m_grant(), 2'(m_owner), m_busy, m_qv, m_q}) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", c, {grant, owner, busy, q_valid, q},
                 {m_grant(), 2'(m_owner), m_busy, m_qv, m_q});
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lone();
    test_round_robin();
    test_release();
    test_wrap();
    test_async_reset();
    test_preempt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
